// File: rtl/riscv_pkg.sv
// Shared core types and defaults: datapath width, PC step, register index type
// and the hard-wired zero register.
package riscv_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int PC_STEP_DEF = 4;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: branch load takes priority over sequential increment,
// otherwise hold. Loaded targets are forced to word alignment.
module pc_unit #(
  parameter int              XLEN     = 32,
  parameter int              PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CK_REF,
  input  logic            RST_N,
  input  logic            PC_INC,
  input  logic            PC_LOAD,
  input  logic [XLEN-1:0] PC_TARGET,
  output logic [XLEN-1:0] PC_OUT
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_nxt;

  // NOTE: combinational blocks assign a default first so no path holds a value (no latch).
  always_comb begin
    pc_nxt = pc_q;
    if (PC_LOAD)
      pc_nxt = {PC_TARGET[XLEN-1:2], 2'b00};
    else if (PC_INC)
      pc_nxt = pc_q + XLEN'(PC_STEP);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) pc_q <= RESET_PC;
    else        pc_q <= pc_nxt;
  end

  assign PC_OUT = pc_q;

endmodule

// File: rtl/register_bank.sv
// Integer register bank (x0 hard-wired to zero) with write scoreboard and PC.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_bank
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              NREGS    = 32,
  parameter int              PC_STEP  = PC_STEP_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             AW       = $clog2(NREGS)
) (
  input  logic            CK_REF,
  input  logic            RST_N,
  input  logic [AW-1:0]   RS1_ADDR,
  input  logic [AW-1:0]   RS2_ADDR,
  output logic [XLEN-1:0] RS1_DATA,
  output logic [XLEN-1:0] RS2_DATA,
  output logic            RS1_BUSY,
  output logic            RS2_BUSY,
  input  logic            WR_EN,
  input  logic [AW-1:0]   WR_ADDR,
  input  logic [XLEN-1:0] WR_DATA,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_RD,
  input  logic            PC_INC,
  input  logic            PC_LOAD,
  input  logic [XLEN-1:0] PC_TARGET,
  output logic [XLEN-1:0] PC_OUT
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_hit;
  logic             issue_hit;

  assign wr_hit    = WR_EN    && !is_zero_reg(reg_idx_t'(WR_ADDR));
  assign issue_hit = ISSUE_EN && !is_zero_reg(reg_idx_t'(ISSUE_RD));

  // NOTE: the array is reset because a reset must leave every register reading zero;
  // storage without that requirement would be left unreset.
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[WR_ADDR] <= WR_DATA;
    end
  end

  // NOTE: the set follows the clear so a same-cycle issue wins (last assignment wins).
  always_comb begin
    busy_nxt = busy_q;
    if (wr_hit)    busy_nxt[WR_ADDR]  = 1'b0;
    if (issue_hit) busy_nxt[ISSUE_RD] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

`ifdef REGFILE_BYPASS_EN
  // Bypass is gated by reset so reads stay zero while reset is held.
  logic byp_hit;
  assign byp_hit = wr_hit && RST_N;
`endif

  always_comb begin
    RS1_DATA = '0;
    RS1_BUSY = 1'b0;
    if (!is_zero_reg(reg_idx_t'(RS1_ADDR))) begin
      RS1_DATA = regs_q[RS1_ADDR];
      RS1_BUSY = busy_q[RS1_ADDR];
`ifdef REGFILE_BYPASS_EN
      if (byp_hit && RS1_ADDR == WR_ADDR) begin
        RS1_DATA = WR_DATA;
        RS1_BUSY = issue_hit && (ISSUE_RD == RS1_ADDR);
      end
`endif
    end
  end

  always_comb begin
    RS2_DATA = '0;
    RS2_BUSY = 1'b0;
    if (!is_zero_reg(reg_idx_t'(RS2_ADDR))) begin
      RS2_DATA = regs_q[RS2_ADDR];
      RS2_BUSY = busy_q[RS2_ADDR];
`ifdef REGFILE_BYPASS_EN
      if (byp_hit && RS2_ADDR == WR_ADDR) begin
        RS2_DATA = WR_DATA;
        RS2_BUSY = issue_hit && (ISSUE_RD == RS2_ADDR);
      end
`endif
    end
  end

  pc_unit #(
    .XLEN     (XLEN),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .CK_REF    (CK_REF),
    .RST_N     (RST_N),
    .PC_INC    (PC_INC),
    .PC_LOAD   (PC_LOAD),
    .PC_TARGET (PC_TARGET),
    .PC_OUT    (PC_OUT)
  );

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus a randomized
// run against an array-based reference model of registers, busy set and PC.
module tb_register_bank;

  logic        ck_ref = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, wr_data, pc_target, pc_out;
  logic        rs1_busy, rs2_busy, wr_en, issue_en, pc_inc, pc_load;

  always #5 ck_ref = ~ck_ref;

  register_bank dut (
    .CK_REF    (ck_ref),
    .RST_N     (rst_n),
    .RS1_ADDR  (rs1_addr),
    .RS2_ADDR  (rs2_addr),
    .RS1_DATA  (rs1_data),
    .RS2_DATA  (rs2_data),
    .RS1_BUSY  (rs1_busy),
    .RS2_BUSY  (rs2_busy),
    .WR_EN     (wr_en),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data),
    .ISSUE_EN  (issue_en),
    .ISSUE_RD  (issue_rd),
    .PC_INC    (pc_inc),
    .PC_LOAD   (pc_load),
    .PC_TARGET (pc_target),
    .PC_OUT    (pc_out)
  );

  // Reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [31:0] m_pc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    m_pc   = '0;
  endtask

  task automatic idle_inputs();
    rs1_addr = '0; rs2_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0;
    pc_inc = 1'b0; pc_load = 1'b0; pc_target = '0;
  endtask

  task automatic random_inputs();
    rs1_addr  = 5'($urandom_range(0, 31));
    rs2_addr  = 5'($urandom_range(0, 31));
    wr_en     = 1'($urandom);
    wr_addr   = 5'($urandom_range(0, 31));
    wr_data   = $urandom;
    issue_en  = 1'($urandom);
    issue_rd  = 5'($urandom_range(0, 31));
    pc_inc    = 1'($urandom);
    pc_load   = ($urandom_range(0, 7) == 0);
    pc_target = $urandom;
  endtask

  // One rising edge; the model absorbs the inputs that were stable at the edge.
  task automatic cycle();
    @(posedge ck_ref);
    if (rst_n) begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (pc_load)     m_pc = pc_target & 32'hFFFF_FFFC;
      else if (pc_inc) m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return issue_en && issue_rd == a;
`endif
    return m_busy[a];
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge ck_ref);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      random_inputs();
      #1;
      n_cmp++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_data: rs1=%h rs2=%h required 0", rs1_data, rs2_data);
      end
      n_cmp++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_busy: rs1=%b rs2=%b required 0", rs1_busy, rs2_busy);
      end
      n_cmp++;
      if (pc_out !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_pc: got %h required 00000000", pc_out);
      end
      @(posedge ck_ref);
      #1;
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rs1_addr = 5'd5;
    cycle();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL write_x5: got %h required deadbeef", rs1_data);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; rs1_addr = 5'd0;
    cycle();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0) begin
      n_bad++;
      $display("FAIL write_x0: got %h required 0", rs1_data);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_now;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
    cycle();
    wr_data = 32'hA5A5_A5A5; rs2_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'hA5A5_A5A5;
`else
    exp_now = 32'h1111_1111;
`endif
    #1;
    n_cmp++;
    if (rs2_data !== exp_now) begin
      n_bad++;
      $display("FAIL bypass_same_cycle: got %h required %h", rs2_data, exp_now);
    end
    cycle();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (rs2_data !== 32'hA5A5_A5A5) begin
      n_bad++;
      $display("FAIL bypass_next_cycle: got %h required a5a5a5a5", rs2_data);
    end
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3;
    cycle();
    issue_en = 1'b0;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_issue: got %b required 1", rs1_busy);
    end
    issue_en = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
    cycle();
    issue_en = 1'b0; wr_en = 1'b0;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_issue_wins: got %b required 1", rs1_busy);
    end
    wr_en = 1'b1; wr_addr = 5'd3;
    cycle();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_writeback: got %b required 0", rs1_busy);
    end
    issue_en = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    cycle();
    issue_en = 1'b0;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_issue_x0: rs1=%b rs2=%b required 0", rs1_busy, rs2_busy);
    end
  endtask

  task automatic test_pc();
    apply_reset();
    pc_inc = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    pc_inc = 1'b0;
    #1;
    n_cmp++;
    if (pc_out !== 32'h0000_000C) begin
      n_bad++;
      $display("FAIL pc_inc3: got %h required 0000000c", pc_out);
    end
    pc_load = 1'b1; pc_inc = 1'b1; pc_target = 32'h0000_1003;
    cycle();
    pc_load = 1'b0; pc_inc = 1'b0;
    #1;
    n_cmp++;
    if (pc_out !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL pc_load_prio: got %h required 00001000", pc_out);
    end
    pc_load = 1'b1; pc_target = 32'hFFFF_FFFC;
    cycle();
    pc_load = 1'b0; pc_inc = 1'b1;
    n_cmp++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL pc_load_top: got %h required fffffffc", pc_out);
    end
    cycle();
    pc_inc = 1'b0;
    #1;
    n_cmp++;
    if (pc_out !== 32'h0) begin
      n_bad++;
      $display("FAIL pc_wrap: got %h required 00000000", pc_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      #1;
      n_cmp++;
      if (rs1_data !== exp_data(rs1_addr) || rs2_data !== exp_data(rs2_addr)) begin
        n_bad++;
        $display("FAIL rand_data[%0d]: rs1 x%0d=%h rs2 x%0d=%h required %h %h", i,
                 rs1_addr, rs1_data, rs2_addr, rs2_data, exp_data(rs1_addr), exp_data(rs2_addr));
      end
      n_cmp++;
      if (rs1_busy !== exp_busy(rs1_addr) || rs2_busy !== exp_busy(rs2_addr)) begin
        n_bad++;
        $display("FAIL rand_busy[%0d]: rs1=%b rs2=%b required %b %b", i,
                 rs1_busy, rs2_busy, exp_busy(rs1_addr), exp_busy(rs2_addr));
      end
      n_cmp++;
      if (pc_out !== m_pc) begin
        n_bad++;
        $display("FAIL rand_pc[%0d]: got %h required %h", i, pc_out, m_pc);
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
    cycle();
    wr_en = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd9; pc_load = 1'b1; pc_target = 32'h0000_0040;
    cycle();
    idle_inputs();
    rs1_addr = 5'd9;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b1 || pc_out !== 32'h0000_0040) begin
      n_bad++;
      $display("FAIL midrst_setup: busy=%b pc=%h required 1 00000040", rs1_busy, pc_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b0 || pc_out !== 32'h0 || rs1_data !== 32'h0) begin
      n_bad++;
      $display("FAIL midrst_clear: busy=%b pc=%h data=%h required 0 0 0",
               rs1_busy, pc_out, rs1_data);
    end
    model_reset();
    @(posedge ck_ref);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_pc();
    test_random();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised integer register bank with integrated program counter and write scoreboard, replacing the fixed 33×32-bit register file in the core datapath. It provides NREGS general-purpose registers with x0 hard-wired to zero, two combinational read ports, one synchronous write port, and a PC register with explicit increment and branch-load control. It also tracks registers with an outstanding write (issued, not yet written back) so the control unit can detect hazards. It sits between decode/issue (read and issue side) and writeback (write side).

## Interface
Parameters:
- XLEN, 32, register and PC width in bits
- NREGS, 32, number of architectural registers; power of two, 2..32
- AW, $clog2(NREGS), register index width (derived, not overridden)
- PC_STEP, 4, PC increment per PC_INC cycle
- RESET_PC, 0, PC value after reset

Ports:
- CK_REF  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- RS1_ADDR  in  AW  read port 1 index
- RS2_ADDR  in  AW  read port 2 index
- RS1_DATA  out  XLEN  read port 1 data
- RS2_DATA  out  XLEN  read port 2 data
- RS1_BUSY  out  1  register at RS1_ADDR has a pending write
- RS2_BUSY  out  1  register at RS2_ADDR has a pending write
- WR_EN  in  1  writeback strobe
- WR_ADDR  in  AW  writeback destination index
- WR_DATA  in  XLEN  writeback data
- ISSUE_EN  in  1  an instruction writing ISSUE_RD is issued this cycle
- ISSUE_RD  in  AW  destination of the issued instruction
- PC_INC  in  1  advance PC by PC_STEP
- PC_LOAD  in  1  load PC from PC_TARGET
- PC_TARGET  in  XLEN  branch/jump target
- PC_OUT  out  XLEN  current PC

## Operation
- Reset (RST_N low, asynchronous): all registers 0, scoreboard all clear, PC = RESET_PC. During and after reset RS1_DATA/RS2_DATA = 0, RSx_BUSY = 0, PC_OUT = RESET_PC.
- Reads: combinational from the array; index 0 always returns 0 and BUSY 0.
- Write: on a rising edge with WR_EN=1 and WR_ADDR≠0, reg[WR_ADDR] ← WR_DATA. WR_ADDR=0 is silently dropped.
- Scoreboard: one busy bit per register, bit 0 constant 0.
  - ISSUE_EN with ISSUE_RD≠0 sets busy[ISSUE_RD].
  - WR_EN with WR_ADDR≠0 clears busy[WR_ADDR].
  - ISSUE_EN and WR_EN to the same index in the same cycle leave the bit set, because the new issue wins.
  - Clearing a bit that is not set is legal and has no effect.
- PC priority: PC_LOAD > PC_INC > hold.
  - On load, PC ← {PC_TARGET[XLEN-1:2], 2'b00}; low bits are discarded.
  - On increment, PC ← PC + PC_STEP modulo 2^XLEN, so 0xFFFFFFFC + 4 wraps to 0.
  - With both PC_LOAD and PC_INC asserted, only the load occurs.
- Reset asserted mid-operation discards pending writes and busy bits immediately, with no completion cycle.

## Timing
- Read latency: 0 cycles (combinational address-to-data).
- Write latency: 1 cycle. Data written at edge N is visible on the read ports after edge N.
- Busy bits and PC update at the edge and are visible in the following cycle.
- No handshake. Every strobe is single-cycle and sampled on each rising edge.

## Configuration
- Macro REGFILE_BYPASS_EN.
  - Defined: a read whose index equals WR_ADDR while WR_EN=1 and WR_ADDR≠0 returns WR_DATA in the same cycle. The matching RSx_BUSY also reads 0 in that cycle unless ISSUE_EN targets the same index.
  - Undefined: reads return array contents only, so the new value appears one cycle after the write.

## Structure
- Shared package riscv_pkg holds:
  - XLEN and PC_STEP defaults
  - the reg_idx_t typedef (5-bit register index)
  - the ZERO_REG constant (0)
- Sub-module pc_unit holds the PC register and its load/increment priority logic. It has parameters XLEN, PC_STEP and RESET_PC and is instantiated once.
- The register array, read muxes, bypass logic and scoreboard stay in register_bank.

## Test plan
- Reset: hold RST_N low with random inputs toggling → all reads 0, BUSY 0, PC_OUT = 0x00000000.
- Write/read: write 0xDEADBEEF to x5 → RS1_ADDR=5 reads 0xDEADBEEF the next cycle. Write 0x12345678 to x0 → x0 still reads 0.
- Bypass:
  - With REGFILE_BYPASS_EN defined, write 0xA5A5A5A5 to x7 with RS2_ADDR=7 → RS2_DATA = 0xA5A5A5A5 in the same cycle.
  - Without the macro, RS2_DATA shows the old value for that cycle and 0xA5A5A5A5 the next.
- Scoreboard:
  - Issue rd=3 → RS1_BUSY for x3 is 1 the next cycle.
  - Issue rd=3 and write back x3 in the same cycle → busy stays 1.
  - Write back x3 alone → busy is 0 the next cycle.
  - Issue rd=0 → busy never set.
- PC:
  - 3 PC_INC cycles from reset → PC_OUT = 0xC.
  - PC_LOAD with target 0x1003 and PC_INC both high → PC_OUT = 0x1000.
  - From 0xFFFFFFFC, one PC_INC → PC_OUT = 0x0.
- Mid-operation reset: RST_N pulsed low between edges with x9 busy and PC = 0x40 → busy and PC clear immediately, before the next edge.
